cordic_engine: RTL and testbench

- Fully pipelined 16-bit CORDIC engine; accepts one operation per clock.
- Rotation mode rotates the vector (x, y) by angle z.
- Vectoring mode returns the magnitude and angle of (x, y).
- Used as the shared trig/vector-math datapath block.
- All I/O is sign-magnitude Q7.8: bit 15 is the sign, bits 14:8 are the integer part, bits 7:0 are the fraction. Angles are in radians.

---
 rtl/cordic_engine.sv | 151 +++++++++++++++
 tb/tb_cordic_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_engine.sv
// Fully pipelined CORDIC engine for sign-magnitude Q7.8 operands (rotation and vectoring).
// The x/y lanes run two bits wider than IW so CORDIC gain and pre-rotation can never wrap.
module cordic_engine #(
    parameter int ITER = 14,
    parameter int IW   = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    output logic [15:0] res1,
    output logic [15:0] res2
);
    localparam int XW = IW + 2;
    localparam int PW = XW + 18;
    localparam int NS = ITER + 2;
    localparam logic signed [IW-1:0] PI     = IW'(205887);
    localparam logic signed [IW-1:0] PI_2   = IW'(102944);
    localparam logic signed [17:0]   KSCALE = 18'sd39797;

    function automatic logic signed [IW-1:0] atan_q16(input int i);
        case (i)
            0:       return IW'(51472);
            1:       return IW'(30385);
            2:       return IW'(16055);
            3:       return IW'(8150);
            4:       return IW'(4091);
            5:       return IW'(2047);
            6:       return IW'(1024);
            7:       return IW'(512);
            default: return IW'(65536 >> i);
        endcase
    endfunction

    function automatic logic signed [XW-1:0] sm_to_tc(input logic [15:0] v);
        logic signed [XW-1:0] mag;
        mag = XW'({v[14:0], 8'h00});
        return v[15] ? -mag : mag;
    endfunction

    // Input carries 32 fraction bits; round half away from zero to 8, saturate, never emit -0.
    function automatic logic [15:0] to_sm(input logic signed [PW-1:0] v);
        logic [PW-1:0] mag;
        logic [PW-1:0] rnd;
        mag = v[PW-1] ? -v : v;
        rnd = (mag + (PW'(1) << 23)) >> 24;
        if (rnd > PW'(32767)) rnd = PW'(32767);
        return {v[PW-1] && (rnd != '0), rnd[14:0]};
    endfunction

    logic signed [XW-1:0] xs [NS];
    logic signed [XW-1:0] ys [NS];
    logic signed [IW-1:0] zs [NS];
    logic                 ms [NS];

    logic signed [XW-1:0] s1_x, s1_y;
    logic signed [IW-1:0] s1_z, zc;

    always_comb begin
        s1_x = xs[0];
        s1_y = ys[0];
        s1_z = '0;
        zc   = zs[0];
        if (ms[0]) begin
            if (zs[0] > PI) zc = PI;
            else if (zs[0] < -PI) zc = -PI;
            s1_z = zc;
            if (zc > PI_2) begin
                s1_x = -xs[0];
                s1_y = -ys[0];
                s1_z = zc - PI;
            end else if (zc < -PI_2) begin
                s1_x = -xs[0];
                s1_y = -ys[0];
                s1_z = zc + PI;
            end
        end else if (xs[0][XW-1]) begin
            s1_x = -xs[0];
            s1_y = -ys[0];
            s1_z = ys[0][XW-1] ? -PI : PI;
        end
    end

    logic signed [XW-1:0] rx [ITER];
    logic signed [XW-1:0] ry [ITER];
    logic signed [IW-1:0] rz [ITER];

    // Condition true means d = -1: z below zero in rotation, y non-negative in vectoring.
    always_comb begin
        for (int i = 0; i < ITER; i++) begin
            rx[i] = xs[i+1];
            ry[i] = ys[i+1];
            rz[i] = zs[i+1];
            if (ms[i+1] ? zs[i+1][IW-1] : !ys[i+1][XW-1]) begin
                rx[i] = xs[i+1] + (ys[i+1] >>> i);
                ry[i] = ys[i+1] - (xs[i+1] >>> i);
                rz[i] = zs[i+1] + atan_q16(i);
            end else begin
                rx[i] = xs[i+1] - (ys[i+1] >>> i);
                ry[i] = ys[i+1] + (xs[i+1] >>> i);
                rz[i] = zs[i+1] - atan_q16(i);
            end
        end
    end

    logic signed [PW-1:0] px, py, pz;
    logic [15:0]          f1, f2;

    // A zero vector leaves x at exactly zero; its angle lane holds junk and is forced to 0.
    always_comb begin
        px = PW'(xs[NS-1]) * PW'(KSCALE);
        py = PW'(ys[NS-1]) * PW'(KSCALE);
        pz = {{(PW-IW-16){zs[NS-1][IW-1]}}, zs[NS-1], 16'h0000};
        f1 = to_sm(px);
        if (ms[NS-1]) f2 = to_sm(py);
        else if (xs[NS-1] == '0) f2 = '0;
        else f2 = to_sm(pz);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NS; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
                zs[i] <= '0;
                ms[i] <= 1'b0;
            end
            res1 <= '0;
            res2 <= '0;
        end else begin
            xs[0] <= sm_to_tc(x);
            ys[0] <= sm_to_tc(y);
            zs[0] <= IW'(sm_to_tc(z));
            ms[0] <= mode;
            xs[1] <= s1_x;
            ys[1] <= s1_y;
            zs[1] <= s1_z;
            ms[1] <= ms[0];
            for (int i = 0; i < ITER; i++) begin
                xs[i+2] <= rx[i];
                ys[i+2] <= ry[i];
                zs[i+2] <= rz[i];
                ms[i+2] <= ms[i+1];
            end
            res1 <= f1;
            res2 <= f2;
        end
    end
endmodule

// File: tb/tb_cordic_engine.sv
// Bench for cordic_engine: directed vector table, back-to-back streams, reset cases,
// and randomized operations checked against real-valued trig math.
module tb_cordic_engine;
    localparam int  LAT = 16;
    localparam real PI  = 3.14159265358979;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        mode  = 1'b0;
    logic [15:0] x     = '0;
    logic [15:0] y     = '0;
    logic [15:0] z     = '0;
    logic [15:0] res1, res2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        m;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        exact;
    } vec_t;

    vec_t        tbl [8];
    logic        s_m  [512];
    logic [15:0] s_x  [512];
    logic [15:0] s_y  [512];
    logic [15:0] s_z  [512];
    real         s_w1 [512];
    real         s_w2 [512];

    cordic_engine #(.ITER(14), .IW(24)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .x(x), .y(y), .z(z),
        .res1(res1), .res2(res2)
    );

    always #5 clk = ~clk;

    function automatic int sm2int(input logic [15:0] v);
        return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
    endfunction

    function automatic real to_lsb(input real v);
        real r;
        r = v * 256.0;
        if (r > 32767.0) r = 32767.0;
        if (r < -32767.0) r = -32767.0;
        return r;
    endfunction

    task automatic model_op(input logic m, input logic [15:0] xi, input logic [15:0] yi,
                            input logic [15:0] zi, output real r1, output real r2);
        real xr, yr, zr;
        xr = sm2int(xi) / 256.0;
        yr = sm2int(yi) / 256.0;
        zr = sm2int(zi) / 256.0;
        if (zr > PI) zr = PI;
        if (zr < -PI) zr = -PI;
        if (m) begin
            r1 = to_lsb(xr * $cos(zr) - yr * $sin(zr));
            r2 = to_lsb(xr * $sin(zr) + yr * $cos(zr));
        end else begin
            r1 = to_lsb($sqrt(xr * xr + yr * yr));
            r2 = (xr == 0.0 && yr == 0.0) ? 0.0 : to_lsb($atan2(yr, xr));
        end
    endtask

    task automatic check_near(input string nm, input logic [15:0] got, input real want);
        real d;
        n_checks++;
        d = real'(sm2int(got)) - want;
        if (d < 0.0) d = -d;
        if (d > 3.0 || got == 16'h8000) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h (%0d lsb), want %0.2f lsb +/-3", nm, got, sm2int(got), want);
        end
    endtask

    task automatic check_exact(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", nm, got, want);
        end
    endtask

    task automatic drive(input logic m, input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] zi);
        mode = m;
        x    = xi;
        y    = yi;
        z    = zi;
    endtask

    task automatic rand_op(input int k);
        logic [15:0] zi;
        real a, b;
        s_m[k] = 1'($urandom_range(0, 1));
        s_x[k] = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 10240))};
        s_y[k] = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 10240))};
        if ($urandom_range(0, 7) == 0) zi = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 32767))};
        else zi = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 1023))};
        s_z[k] = zi;
        model_op(s_m[k], s_x[k], s_y[k], zi, a, b);
        s_w1[k] = a;
        s_w2[k] = b;
    endtask

    // Op k is driven at negedge k and its result is visible at negedge k+LAT+1.
    task automatic run_stream(input int n, input string tag);
        for (int k = 0; k <= n + LAT; k++) begin
            @(negedge clk);
            if (k >= LAT + 1) begin
                check_near($sformatf("%s[%0d].res1", tag, k - LAT - 1), res1, s_w1[k-LAT-1]);
                check_near($sformatf("%s[%0d].res2", tag, k - LAT - 1), res2, s_w2[k-LAT-1]);
            end
            if (k < n) drive(s_m[k], s_x[k], s_y[k], s_z[k]);
            else drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h1A60, 16'h0E00, 16'h0200, 16'h97B5, 16'h1228, 1'b0};
        tbl[1] = '{1'b1, 16'h1A60, 16'h0E00, 16'h8310, 16'h9930, 16'h900A, 1'b0};
        tbl[2] = '{1'b0, 16'h1A60, 16'h0E00, 16'h0000, 16'h1DDC, 16'h007D, 1'b0};
        tbl[3] = '{1'b0, 16'h9A60, 16'h0E00, 16'h0000, 16'h1DDC, 16'h02A7, 1'b0};
        tbl[4] = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b1};
        tbl[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        tbl[6] = '{1'b0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h00C9, 1'b0};
        tbl[7] = '{1'b1, 16'h0A00, 16'h0000, 16'h7FFF, 16'h8A00, 16'h0000, 1'b0};

        #1 reset = 1'b0;
        #1;
        check_exact("reset.res1", res1, 16'h0000);
        check_exact("reset.res2", res2, 16'h0000);
        repeat (2) @(negedge clk);
        check_exact("reset_held.res1", res1, 16'h0000);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(tbl[i].m, tbl[i].x, tbl[i].y, tbl[i].z);
            @(negedge clk);
            drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
            repeat (LAT) @(negedge clk);
            if (tbl[i].exact) begin
                check_exact($sformatf("vec%0d.res1", i), res1, tbl[i].e1);
                check_exact($sformatf("vec%0d.res2", i), res2, tbl[i].e2);
            end else begin
                check_near($sformatf("vec%0d.res1", i), res1, real'(sm2int(tbl[i].e1)));
                check_near($sformatf("vec%0d.res2", i), res2, real'(sm2int(tbl[i].e2)));
            end
        end

        // Alternating modes on consecutive clocks.
        begin
            int order [4] = '{0, 2, 1, 3};
            for (int k = 0; k < 4; k++) begin
                s_m[k]  = tbl[order[k]].m;
                s_x[k]  = tbl[order[k]].x;
                s_y[k]  = tbl[order[k]].y;
                s_z[k]  = tbl[order[k]].z;
                s_w1[k] = real'(sm2int(tbl[order[k]].e1));
                s_w2[k] = real'(sm2int(tbl[order[k]].e2));
            end
        end
        run_stream(4, "b2b");

        for (int k = 0; k < 300; k++) rand_op(k);
        run_stream(300, "rand");

        // Reset with the pipeline full, then refill from empty.
        for (int k = 0; k < 20; k++) rand_op(k);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k >= LAT + 1) begin
                check_near($sformatf("prefill[%0d].res1", k - LAT - 1), res1, s_w1[k-LAT-1]);
                check_near($sformatf("prefill[%0d].res2", k - LAT - 1), res2, s_w2[k-LAT-1]);
            end
            drive(s_m[k], s_x[k], s_y[k], s_z[k]);
        end
        #2 reset = 1'b0;
        #1;
        check_exact("midreset.res1", res1, 16'h0000);
        check_exact("midreset.res2", res2, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(tbl[0].m, tbl[0].x, tbl[0].y, tbl[0].z);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
            check_exact($sformatf("refill%0d.res1", k), res1, 16'h0000);
            check_exact($sformatf("refill%0d.res2", k), res2, 16'h0000);
        end
        @(negedge clk);
        check_near("refill.res1", res1, real'(sm2int(tbl[0].e1)));
        check_near("refill.res2", res2, real'(sm2int(tbl[0].e2)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
